alu: RTL and testbench
======================

# alu

Registered 32-bit integer ALU for the RV32I execute stage. Decodes a 4-bit operation code in the RV32I `{funct7[5], funct3}` form and computes a result plus five status flags. Both outputs are captured on the rising clock edge. It sits between operand selection and writeback/branch-resolution logic.

## Interface
- No parameters. Data width is fixed at 32 bits and op width at 4 bits.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  32  operand A.
- B  input  32  operand B; B[4:0] is the shift amount.
- op  input  4  operation select, encoded as `{funct7[5], funct3}`.
- result  output  32  registered result.
- status  output  5  registered flags, defined as:
  - [0] Z: result == 0.
  - [1] N: result[31].
  - [2] C: carry.
  - [3] V: signed overflow.
  - [4] ILL: unsupported op.

## Operation
- Op encodings:
  - ADD 0000: A+B.
  - SUB 1000: A−B.
  - XOR 0100: A^B.
  - OR 0110: A|B.
  - AND 0111: A&B.
- Op encodings present only when ALU_SHIFT_EN is defined:
  - SLL 0001: A<<B[4:0].
  - SLT 0010: signed A<B → 1, else 0.
  - SLTU 0011: unsigned A<B → 1, else 0.
  - SRL 0101: logical A>>B[4:0].
  - SRA 1101: arithmetic A>>>B[4:0].
- Arithmetic is modulo 2^32, with no exceptions.
- SUB is computed as A + ~B + 1.
- C flag:
  - ADD: carry-out of bit 31.
  - SUB: carry-out of A + ~B + 1, so C=1 means no borrow (A ≥ B unsigned).
  - All other ops: C=0.
- V flag:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - All other ops: V=0.
- Z and N are derived from the final 32-bit result for every op, including SLT/SLTU.
- Any encoding not listed as enabled:
  - result = 0.
  - Z=1, N=0, C=0, V=0, ILL=1.
- ILL=0 for every supported op.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge k appear on result/status after edge k.
- No handshake. A new operation is accepted every cycle.
- Outputs hold their value between edges. Input changes between edges have no effect until the next edge.
- Reset:
  - rst=1 at an edge → result=32'h0, status=5'b00000 after that edge. This takes priority over any op.
  - Reset mid-stream discards the operation sampled at that edge.
  - The first valid result follows the first edge with rst=0.
- Shift amounts use only B[4:0]; B[31:5] is ignored. Shift by 0 passes A unchanged.
- X/undefined inputs while rst=1 must not propagate to outputs.

## Configuration
- Macro: ALU_SHIFT_EN.
- Defined: SLL, SLT, SLTU, SRL and SRA are implemented as specified.
- Not defined:
  - Encodings 0001, 0010, 0011, 0101 and 1101 take the unsupported-op path (result 0, ILL=1).
  - No shifter or comparator logic is synthesized.
- ADD/SUB/AND/OR/XOR behave identically in both builds.

## Structure
- Package alu_pkg holds:
  - Op-code localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_SRL, ALU_SRA.
  - Status bit index constants: ST_Z, ST_N, ST_C, ST_V, ST_ILL.
- Sub-module alu_addsub:
  - Shared 33-bit adder with conditional B inversion and carry-in.
  - Outputs sum, C and V.
  - Reused by ADD, SUB, SLT and SLTU.
- The top level holds the combinational op mux, flag derivation and output registers.

## Test plan
- rst=1 for 1 edge with X operands → result=0, status=00000. Release rst, A=9, B=10, op=ADD → result=19, status=00000 one edge later.
- A=9, B=10, op=SUB → result=32'hFFFFFFFF, N=1, C=0, V=0, Z=0.
- A=10, B=10, op=SUB → result=0, Z=1, C=1, N=0, V=0.
- A=1, B=1, op=AND → result=1, status=00000. Same operands with op=OR → 1; with op=XOR → 0, Z=1.
- A=32'h7FFFFFFF, B=1, op=ADD → result=32'h80000000, N=1, V=1, C=0. A=32'hFFFFFFFF, B=1, op=ADD → result=0, Z=1, C=1.
- op=4'b1111 → result=0, status=5'b10001.
- With ALU_SHIFT_EN: A=32'h80000000, B=33, op=SRA → result=32'hC0000000.
- Without ALU_SHIFT_EN: the same stimulus gives ILL=1 and result=0.
- Assert rst=1 while a SUB is presented → outputs zero after that edge.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the RV32I execute-stage ALU.
//   - Op codes in {funct7[5], funct3} form.
//   - Bit positions of the status flags.
// Optional feature macro: ALU_SHIFT_EN (SLL/SLT/SLTU/SRL/SRA).
// The op-code constants exist in both builds. Only the ALU decides
// whether an encoding is supported.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int ST_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;

    localparam int ST_Z   = 0;
    localparam int ST_N   = 1;
    localparam int ST_C   = 2;
    localparam int ST_V   = 3;
    localparam int ST_ILL = 4;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between operand selection and the ALU.
//   A, B    : operands (B[4:0] is the shift amount)
//   op      : operation select {funct7[5], funct3}
//   result  : registered result
//   status  : registered flags {ILL, V, C, N, Z}
// Modports:
//   master : the side that drives operands
//   slave  : the ALU
// Optional feature macro: ALU_SHIFT_EN. It does not change this interface.
interface alu_if;
    import alu_pkg::*;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] result;
    logic [ST_W-1:0]   status;

    modport master (output A, output B, output op, input result, input status);
    modport slave  (input A, input B, input op, output result, output status);
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub: shared 33-bit adder for the ALU.
//   a_i, b_i : operands
//   sub_i    : 1 -> a + ~b + 1, 0 -> a + b
//   sum_o    : low 32 bits of the sum
//   c_o      : carry-out of bit 31 (for SUB, 1 means no borrow)
//   v_o      : signed overflow of the selected operation
// Optional feature macro: ALU_SHIFT_EN. The compare ops then reuse this
// adder, and this module is the same in both builds.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              c_o,
    output logic              v_o
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum_ext;

    assign b_eff   = b_i ^ {DATA_W{sub_i}};
    assign sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
    assign sum_o   = sum_ext[DATA_W-1:0];
    assign c_o     = sum_ext[DATA_W];
    // Overflow is checked on the operands actually added. For SUB, the
    // inverted B gives "signs differ and the result sign differs from A".
    assign v_o     = (a_i[DATA_W-1] == b_eff[DATA_W-1]) &&
                     (sum_o[DATA_W-1] != a_i[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// alu: registered 32-bit RV32I integer ALU.
// Ports:
//   clk : system clock; all state updates on its rising edge
//   rst : synchronous reset, active-high; clears result and status
//   bus : alu_if.slave (A, B, op in; result, status out)
// Latency is one cycle. A new operation is accepted every cycle.
// Optional feature macro: ALU_SHIFT_EN. It enables SLL, SLT, SLTU, SRL
// and SRA. Without it, those encodings are reported as illegal.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [DATA_W-1:0] sum;
    logic              add_c;
    logic              add_v;
    logic              use_sub;

    logic [DATA_W-1:0] result_d, result_q;
    logic [ST_W-1:0]   status_d, status_q;
    logic              c_d, v_d, ill_d;

`ifdef ALU_SHIFT_EN
    // SLT and SLTU compare by running A - B through the shared adder.
    assign use_sub = (bus.op == ALU_SUB) || (bus.op == ALU_SLT) ||
                     (bus.op == ALU_SLTU);
`else
    assign use_sub = (bus.op == ALU_SUB);
`endif

    alu_addsub u_addsub (
        .a_i   (bus.A),
        .b_i   (bus.B),
        .sub_i (use_sub),
        .sum_o (sum),
        .c_o   (add_c),
        .v_o   (add_v)
    );

    always_comb begin
        result_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        ill_d    = 1'b0;
        case (bus.op)
            ALU_ADD, ALU_SUB: begin
                result_d = sum;
                c_d      = add_c;
                v_d      = add_v;
            end
            ALU_XOR: result_d = bus.A ^ bus.B;
            ALU_OR:  result_d = bus.A | bus.B;
            ALU_AND: result_d = bus.A & bus.B;
`ifdef ALU_SHIFT_EN
            ALU_SLL:  result_d = bus.A << bus.B[4:0];
            ALU_SRL:  result_d = bus.A >> bus.B[4:0];
            ALU_SRA:  result_d = $unsigned($signed(bus.A) >>> bus.B[4:0]);
            // For SLT, signed less-than is the sign of A-B, corrected for overflow.
            ALU_SLT:  result_d = {{(DATA_W-1){1'b0}}, sum[DATA_W-1] ^ add_v};
            // For SLTU, a missing carry out of A + ~B + 1 means a borrow, so A < B.
            ALU_SLTU: result_d = {{(DATA_W-1){1'b0}}, ~add_c};
`endif
            default: ill_d = 1'b1;
        endcase

        status_d         = '0;
        status_d[ST_Z]   = (result_d == '0);
        status_d[ST_N]   = result_d[DATA_W-1];
        status_d[ST_C]   = c_d;
        status_d[ST_V]   = v_d;
        status_d[ST_ILL] = ill_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            status_q <= '0;
        end else begin
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign bus.result = result_q;
    assign bus.status = status_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu.
// The driver applies one operation per cycle on the falling edge. It
// queues the response expected from a reference model written directly
// from the arithmetic rules. A monitor runs 1 ns after each rising edge
// and compares the DUT outputs with the oldest queued entry.
// Build with +define+ALU_SHIFT_EN to exercise the shift/compare ops.
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] r;
        logic [4:0]  s;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op,
                                  output logic [31:0] r, output logic [4:0] s);
        longint unsigned ua = {32'b0, a};
        longint unsigned ub = {32'b0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          smax = 64'sd2147483647;
        longint          smin = -smax - 1;
        longint          t;
        bit              c = 0, v = 0, ill = 0;
        r = 32'h0;
        case (op)
            4'b0000: begin
                r = a + b;
                c = (ua + ub) >= 64'h1_0000_0000;
                t = sa + sb;
                v = (t > smax) || (t < smin);
            end
            4'b1000: begin
                r = a - b;
                c = (ua >= ub);
                t = sa - sb;
                v = (t > smax) || (t < smin);
            end
            4'b0100: r = a ^ b;
            4'b0110: r = a | b;
            4'b0111: r = a & b;
`ifdef ALU_SHIFT_EN
            4'b0001: r = a << b[4:0];
            4'b0101: r = a >> b[4:0];
            4'b1101: r = $signed(a) >>> b[4:0];
            4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
`endif
            default: ill = 1;
        endcase
        s = {ill, v, c, r[31], r == 32'h0};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic r_in, input string name);
        exp_t e;
        @(negedge clk);
        rst    = r_in;
        bus.A  = a;
        bus.B  = b;
        bus.op = op;
        e.name = name;
        if (r_in) begin
            e.r = 32'h0;
            e.s = 5'b0;
        end else begin
            model(a, b, op, e.r, e.s);
        end
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (bus.result !== e.r || bus.status !== e.s) begin
                n_err++;
                $display("FAIL %s: got result=%h status=%b, want result=%h status=%b",
                         e.name, bus.result, bus.status, e.r, e.s);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        bus.A  = 'x;
        bus.B  = 'x;
        bus.op = 'x;
        drive('x, 'x, 'x, 1'b1, "reset_x");
        drive(32'd9, 32'd10, ALU_ADD, 1'b0, "add_9_10");
        drive(32'd9, 32'd10, ALU_SUB, 1'b0, "sub_9_10");
        drive(32'd10, 32'd10, ALU_SUB, 1'b0, "sub_10_10");
        drive(32'd1, 32'd1, ALU_AND, 1'b0, "and_1_1");
        drive(32'd1, 32'd1, ALU_OR, 1'b0, "or_1_1");
        drive(32'd1, 32'd1, ALU_XOR, 1'b0, "xor_1_1");
        drive(32'h7FFF_FFFF, 32'd1, ALU_ADD, 1'b0, "add_ovf");
        drive(32'hFFFF_FFFF, 32'd1, ALU_ADD, 1'b0, "add_carry");
        drive(32'h8000_0000, 32'd1, ALU_SUB, 1'b0, "sub_ovf");
        drive(32'h1234_5678, 32'h0, 4'b1111, 1'b0, "illegal_1111");
        drive(32'h8000_0000, 32'd33, ALU_SRA, 1'b0, "sra_b33");
        drive(32'hDEAD_BEEF, 32'hFFFF_FFE0, ALU_SLL, 1'b0, "sll_by_0");
        drive(32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b0, "slt_neg");
        drive(32'hFFFF_FFFF, 32'd1, ALU_SLTU, 1'b0, "sltu_big");
        drive(32'd9, 32'd10, ALU_SUB, 1'b1, "rst_mid_sub");
        drive(32'd3, 32'd4, ALU_ADD, 1'b0, "add_after_rst");

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op_r;
            op_r = 4'($urandom_range(0, 15));
            drive(pick32(), pick32(), op_r, ($urandom_range(0, 31) == 0), "random");
        end

        // Leave the inputs idle and wait a bounded time for the queue to drain.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries still queued, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
